// File: rtl/platform_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | platform_pkg                                                         |
// | Shared types for the platform-world manager: the 12-bit signed       |
// | coordinate, the platform kind and the kind decode of a random slice. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package platform_pkg;

  typedef logic signed [11:0] coord_t;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_STATIC = 2'd1,
    KIND_MOVING = 2'd2,
    KIND_BREAK  = 2'd3
  } kind_t;

  // Two LFSR bits map one-to-one onto a kind.
  function automatic kind_t kind_decode(input logic [1:0] bits);
    return kind_t'(bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/platform_field_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | platform_field_if                                                    |
// | Frame controls, doodle/beam inputs and platform/pixel results of the |
// | platform-world manager.                                              |
// |   master : drives frame_tick, rnd, shift_req, doodle_*, beam_*       |
// |   slave  : drives plat_*, scrolling, land*, break*, pix_*            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface platform_field_if #(
  parameter int N     = 90,
  parameter int RND_W = 30,
  parameter int IDX_W = $clog2(N)
);
  import platform_pkg::*;

  logic             frame_tick;
  logic [RND_W-1:0] rnd;
  logic             shift_req;
  coord_t           doodle_x;
  coord_t           doodle_y;
  logic             doodle_falling;
  logic [10:0]      beam_x;
  logic [9:0]       beam_y;

  coord_t           plat_y [N];
  coord_t           plat_x [N];
  kind_t            plat_kind [N];
  logic             scrolling;
  logic             land;
  logic [IDX_W-1:0] land_idx;
  logic             break_evt;
  logic [IDX_W-1:0] break_idx;
  logic             pix_hit;
  logic [IDX_W-1:0] pix_idx;
  kind_t            pix_kind;
  logic [6:0]       pix_dx;
  logic [4:0]       pix_dy;

  modport master (
    output frame_tick, rnd, shift_req, doodle_x, doodle_y, doodle_falling, beam_x, beam_y,
    input  plat_y, plat_x, plat_kind, scrolling, land, land_idx, break_evt, break_idx,
    input  pix_hit, pix_idx, pix_kind, pix_dx, pix_dy
  );

  modport slave (
    input  frame_tick, rnd, shift_req, doodle_x, doodle_y, doodle_falling, beam_x, beam_y,
    output plat_y, plat_x, plat_kind, scrolling, land, land_idx, break_evt, break_idx,
    output pix_hit, pix_idx, pix_kind, pix_dx, pix_dy
  );

endinterface
`default_nettype wire

// File: rtl/platform_pixel_hit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | platform_pixel_hit                                                   |
// | Per-pixel platform lookup: N parallel box compares, lowest-index     |
// | priority select and a one-cycle output register.                     |
// |   in  : clk, rst, beam_x, beam_y, plat_y/plat_x/plat_kind arrays     |
// |   out : pix_hit, pix_idx, pix_kind, pix_dx, pix_dy                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module platform_pixel_hit
  import platform_pkg::*;
#(
  parameter int N      = 90,
  parameter int PLAT_W = 100,
  parameter int PLAT_H = 30,
  parameter int IDX_W  = $clog2(N)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [10:0] beam_x,
  input  wire logic [9:0]  beam_y,
  input  coord_t           plat_y [N],
  input  coord_t           plat_x [N],
  input  kind_t            plat_kind [N],
  output logic             pix_hit,
  output logic [IDX_W-1:0] pix_idx,
  output kind_t            pix_kind,
  output logic [6:0]       pix_dx,
  output logic [4:0]       pix_dy
);

  localparam coord_t c_plat_w = coord_t'(PLAT_W);
  localparam coord_t c_plat_h = coord_t'(PLAT_H);

  // Beam coordinates are unsigned; zero-extend so they compare as positive.
  coord_t     w_bx;
  coord_t     w_by;
  logic [N-1:0] w_draw;

  assign w_bx = coord_t'({1'b0, beam_x});
  assign w_by = coord_t'({2'b00, beam_y});

  generate
    for (genvar i = 0; i < N; i++) begin : g_cmp
      assign w_draw[i] = (plat_kind[i] != KIND_NONE) &&
                         (w_bx >= plat_x[i]) && (w_bx < plat_x[i] + c_plat_w) &&
                         (w_by >= plat_y[i]) && (w_by < plat_y[i] + c_plat_h);
    end
  endgenerate

  logic             w_any;
  logic [IDX_W-1:0] w_sel;
  kind_t            w_kind;
  coord_t           w_dx;
  coord_t           w_dy;

  // Walk from the top index down so the lowest drawn index is left standing.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_kind = KIND_NONE;
    w_dx   = '0;
    w_dy   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_draw[i]) begin
        w_any  = 1'b1;
        w_sel  = IDX_W'(i);
        w_kind = plat_kind[i];
        w_dx   = w_bx - plat_x[i];
        w_dy   = w_by - plat_y[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_any) begin
      pix_hit  <= 1'b0;
      pix_idx  <= '0;
      pix_kind <= KIND_NONE;
      pix_dx   <= '0;
      pix_dy   <= '0;
    end else begin
      pix_hit  <= 1'b1;
      pix_idx  <= w_sel;
      pix_kind <= w_kind;
      pix_dx   <= w_dx[6:0];
      pix_dy   <= w_dy[4:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/platform_field.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | platform_field                                                       |
// | Platform-world manager: per frame scrolls the world, recycles row    |
// | groups past the earth line, animates moving platforms and detects    |
// | doodle landings; per pixel reports the platform under the beam.      |
// |   in  : clk, rst (sync, active-high), bus (platform_field_if.slave)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module platform_field
  import platform_pkg::*;
#(
  parameter int ROWS         = 30,
  parameter int COLS         = 3,
  parameter int GROUP_ROWS   = 5,
  parameter int ROW_Y0       = -162,
  parameter int ROW_PITCH    = 30,
  parameter int COL_X0       = 342,
  parameter int COL_PITCH    = 114,
  parameter int PLAT_W       = 100,
  parameter int PLAT_H       = 30,
  parameter int EARTH        = 480,
  parameter int WRAP         = 948,
  parameter int WORLD_SHIFT  = 4,
  parameter int SHIFT_FRAMES = 16,
  parameter int MOVE_SPEED   = 2,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 1024,
  parameter int DOODLE_W     = 60,
  parameter int DOODLE_H     = 60,
  parameter int LAND_TOL     = 8,
  parameter logic [ROWS*COLS-1:0] INIT_ACTIVE = '1
) (
  input wire logic       clk,
  input wire logic       rst,
  platform_field_if.slave bus
);

  localparam int     c_n      = ROWS * COLS;
  localparam int     c_gsize  = GROUP_ROWS * COLS;
  localparam int     c_idx_w  = $clog2(c_n);
  localparam int     c_cnt_w  = $clog2(SHIFT_FRAMES + 1);
  localparam coord_t c_earth  = coord_t'(EARTH);
  localparam coord_t c_wrap   = coord_t'(WRAP);
  localparam coord_t c_shift  = coord_t'(WORLD_SHIFT);
  localparam coord_t c_speed  = coord_t'(MOVE_SPEED);
  localparam coord_t c_lo     = coord_t'(X_MIN);
  localparam coord_t c_hi     = coord_t'(X_MAX - PLAT_W);
  localparam coord_t c_plat_w = coord_t'(PLAT_W);
  localparam coord_t c_dood_w = coord_t'(DOODLE_W);
  localparam coord_t c_dood_h = coord_t'(DOODLE_H);
  localparam coord_t c_tol    = coord_t'(LAND_TOL);

  coord_t             r_y    [c_n];
  coord_t             r_x    [c_n];
  kind_t              r_kind [c_n];
  logic [c_n-1:0]     r_dir;            // 0 = rightward
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_land;
  logic [c_idx_w-1:0] r_land_idx;
  logic               r_brk;
  logic [c_idx_w-1:0] r_brk_idx;

  coord_t             w_ny    [c_n];
  coord_t             w_nx    [c_n];
  kind_t              w_nkind [c_n];
  logic [c_n-1:0]     w_ndir;
  kind_t              w_fresh [c_gsize];
  logic               w_any_fresh;
  coord_t             w_shift;
  coord_t             w_feet;
  coord_t             w_step;
  logic               w_hit;
  logic               w_hit_brk;
  logic [c_idx_w-1:0] w_hit_idx;

  // Whole frame step is computed from the pre-tick state and committed at once.
  always_comb begin
    w_shift     = (bus.shift_req || (r_cnt != '0)) ? c_shift : '0;
    w_any_fresh = 1'b0;
    w_feet      = bus.doodle_y + c_dood_h;
    w_step      = '0;
    w_hit       = 1'b0;
    w_hit_brk   = 1'b0;
    w_hit_idx   = '0;
    w_ndir      = r_dir;

    // Every recycling group shares the same fresh kinds.
    for (int k = 0; k < c_gsize; k++) begin
      w_fresh[k] = kind_decode(bus.rnd[2*k +: 2]);
      if (w_fresh[k] != KIND_NONE) w_any_fresh = 1'b1;
    end
    if (!w_any_fresh) w_fresh[c_gsize-1] = KIND_STATIC;

    for (int i = c_n - 1; i >= 0; i--) begin
      if (bus.doodle_falling && (r_kind[i] != KIND_NONE) &&
          (bus.doodle_x < r_x[i] + c_plat_w) && (r_x[i] < bus.doodle_x + c_dood_w) &&
          (w_feet >= r_y[i]) && (w_feet < r_y[i] + c_tol)) begin
        w_hit     = 1'b1;
        w_hit_brk = (r_kind[i] == KIND_BREAK);
        w_hit_idx = c_idx_w'(i);
      end
    end

    for (int i = 0; i < c_n; i++) begin
      w_ny[i]    = r_y[i] + w_shift;
      w_nx[i]    = r_x[i];
      w_nkind[i] = r_kind[i];

      // Reaching a bound already turns the platform around.
      if (r_kind[i] == KIND_MOVING) begin
        if (!r_dir[i]) begin
          w_step = r_x[i] + c_speed;
          if (w_step >= c_hi) begin
            w_nx[i]   = c_hi;
            w_ndir[i] = 1'b1;
          end else begin
            w_nx[i] = w_step;
          end
        end else begin
          w_step = r_x[i] - c_speed;
          if (w_step <= c_lo) begin
            w_nx[i]   = c_lo;
            w_ndir[i] = 1'b0;
          end else begin
            w_nx[i] = w_step;
          end
        end
      end

      if (w_hit && w_hit_brk && (int'(w_hit_idx) == i)) w_nkind[i] = KIND_NONE;

      // Recycling overrides any other per-frame update of the platform.
      if (r_y[(i / c_gsize) * c_gsize] >= c_earth) begin
        w_ny[i]    = r_y[i] + w_shift - c_wrap;
        w_nx[i]    = r_x[i];
        w_nkind[i] = w_fresh[i % c_gsize];
        w_ndir[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_n; i++) begin
        r_y[i]    <= coord_t'(ROW_Y0 + (i / COLS) * ROW_PITCH);
        r_x[i]    <= coord_t'(COL_X0 + (i % COLS) * COL_PITCH);
        r_kind[i] <= INIT_ACTIVE[i] ? KIND_STATIC : KIND_NONE;
      end
      r_dir      <= '0;
      r_cnt      <= '0;
      r_land     <= 1'b0;
      r_land_idx <= '0;
      r_brk      <= 1'b0;
      r_brk_idx  <= '0;
    end else begin
      r_land <= 1'b0;
      r_brk  <= 1'b0;
      if (bus.frame_tick) begin
        for (int i = 0; i < c_n; i++) begin
          r_y[i]    <= w_ny[i];
          r_x[i]    <= w_nx[i];
          r_kind[i] <= w_nkind[i];
        end
        r_dir <= w_ndir;
        if (bus.shift_req)    r_cnt <= c_cnt_w'(SHIFT_FRAMES);
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        if (w_hit) begin
          if (w_hit_brk) begin
            r_brk     <= 1'b1;
            r_brk_idx <= w_hit_idx;
          end else begin
            r_land     <= 1'b1;
            r_land_idx <= w_hit_idx;
          end
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < c_n; i++) begin : g_out
      assign bus.plat_y[i]    = r_y[i];
      assign bus.plat_x[i]    = r_x[i];
      assign bus.plat_kind[i] = r_kind[i];
    end
  endgenerate

  assign bus.scrolling = (r_cnt != '0);
  assign bus.land      = r_land;
  assign bus.land_idx  = r_land_idx;
  assign bus.break_evt = r_brk;
  assign bus.break_idx = r_brk_idx;

  platform_pixel_hit #(
    .N      (c_n),
    .PLAT_W (PLAT_W),
    .PLAT_H (PLAT_H),
    .IDX_W  (c_idx_w)
  ) u_pixel_hit (
    .clk       (clk),
    .rst       (rst),
    .beam_x    (bus.beam_x),
    .beam_y    (bus.beam_y),
    .plat_y    (r_y),
    .plat_x    (r_x),
    .plat_kind (r_kind),
    .pix_hit   (bus.pix_hit),
    .pix_idx   (bus.pix_idx),
    .pix_kind  (bus.pix_kind),
    .pix_dx    (bus.pix_dx),
    .pix_dy    (bus.pix_dy)
  );

endmodule
`default_nettype wire

// File: tb/tb_platform_field.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_platform_field                                                    |
// | Randomised self-checking bench for platform_field against an         |
// | integer reference model of the platform world.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_platform_field;
  import platform_pkg::*;

  localparam int c_n     = 90;
  localparam int c_gsize = 15;
  localparam logic [89:0] c_init_active = {30{3'b011}};

  logic clk;
  logic rst;

  platform_field_if #(.N(c_n), .RND_W(30)) bus ();

  platform_field #(.INIT_ACTIVE(c_init_active)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference world: plain integers, kinds 0=NONE 1=STATIC 2=MOVING 3=BREAK.
  int m_y [c_n];
  int m_x [c_n];
  int m_k [c_n];
  int m_d [c_n];
  int m_cnt;
  int e_land, e_land_idx, e_brk, e_brk_idx;
  int e_hit, e_idx, e_kind, e_dx, e_dy;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d required %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int w12(input int v);
    int t;
    t = v & 32'hFFF;
    return (t >= 2048) ? t - 4096 : t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < c_n; i++) begin
      m_y[i] = -162 + (i / 3) * 30;
      m_x[i] = 342 + (i % 3) * 114;
      m_k[i] = c_init_active[i] ? 1 : 0;
      m_d[i] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_pixel(input int bx, input int by);
    e_hit = 0; e_idx = 0; e_kind = 0; e_dx = 0; e_dy = 0;
    for (int i = 0; i < c_n; i++) begin
      if (e_hit == 0 && m_k[i] != 0 && bx >= m_x[i] && bx < w12(m_x[i] + 100) &&
          by >= m_y[i] && by < w12(m_y[i] + 30)) begin
        e_hit = 1; e_idx = i; e_kind = m_k[i];
        e_dx = (bx - m_x[i]) & 127;
        e_dy = (by - m_y[i]) & 31;
      end
    end
  endtask

  task automatic model_frame(input int shreq, input logic [29:0] rnd, input int dx, input int dy, input int fall);
    int py [c_n]; int px [c_n]; int pk [c_n]; int pd [c_n];
    int fresh [c_gsize];
    int sh, s, allnone, feet, lead;
    py = m_y; px = m_x; pk = m_k; pd = m_d;
    sh = (shreq != 0 || m_cnt > 0) ? 4 : 0;
    m_cnt = (shreq != 0) ? 16 : ((m_cnt > 0) ? m_cnt - 1 : 0);
    allnone = 1;
    for (int j = 0; j < c_gsize; j++) begin
      fresh[j] = (rnd >> (2 * j)) & 3;
      if (fresh[j] != 0) allnone = 0;
    end
    if (allnone != 0) fresh[c_gsize-1] = 1;
    e_land = 0; e_land_idx = 0; e_brk = 0; e_brk_idx = 0;
    feet = w12(dy + 60);
    if (fall != 0) begin
      for (int i = 0; i < c_n; i++) begin
        if (e_land == 0 && e_brk == 0 && pk[i] != 0 && dx < w12(px[i] + 100) && px[i] < w12(dx + 60) &&
            feet >= py[i] && feet < w12(py[i] + 8)) begin
          if (pk[i] == 3) begin e_brk = 1; e_brk_idx = i; end
          else begin e_land = 1; e_land_idx = i; end
        end
      end
    end
    for (int i = 0; i < c_n; i++) begin
      m_y[i] = w12(py[i] + sh);
      if (pk[i] == 2) begin
        s = (pd[i] == 0) ? w12(px[i] + 2) : w12(px[i] - 2);
        if (pd[i] == 0 && s >= 924) begin m_x[i] = 924; m_d[i] = 1; end
        else if (pd[i] != 0 && s <= 0) begin m_x[i] = 0; m_d[i] = 0; end
        else m_x[i] = s;
      end
      if (e_brk != 0 && i == e_brk_idx) m_k[i] = 0;
      lead = (i / c_gsize) * c_gsize;
      if (py[lead] >= 480) begin
        m_y[i] = w12(py[i] + sh - 948);
        m_x[i] = px[i];
        m_k[i] = fresh[i % c_gsize];
        m_d[i] = 0;
      end
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < c_n; i++) begin
      check("plat_y", bus.plat_y[i], m_y[i]);
      check("plat_x", bus.plat_x[i], m_x[i]);
      check("plat_kind", bus.plat_kind[i], m_k[i]);
    end
    check("scrolling", bus.scrolling, (m_cnt != 0) ? 1 : 0);
  endtask

  task automatic check_outputs();
    check("pix_hit", bus.pix_hit, e_hit);
    check("pix_idx", bus.pix_idx, e_idx);
    check("pix_kind", bus.pix_kind, e_kind);
    check("pix_dx", bus.pix_dx, e_dx);
    check("pix_dy", bus.pix_dy, e_dy);
    check("land", bus.land, e_land);
    if (e_land != 0) check("land_idx", bus.land_idx, e_land_idx);
    check("break_evt", bus.break_evt, e_brk);
    if (e_brk != 0) check("break_idx", bus.break_idx, e_brk_idx);
  endtask

  task automatic cycle(input int tick, input int shift_prob);
    int j, bx, by, dx, dy, fall, sreq;
    logic [29:0] r;
    j  = $urandom_range(0, c_n - 1);
    bx = (m_x[j] + $urandom_range(0, 109) - 5) & 2047;
    by = (m_y[j] + $urandom_range(0, 39) - 5) & 1023;
    bus.beam_x = 11'(bx);
    bus.beam_y = 10'(by);
    model_pixel(bx, by);
    e_land = 0; e_brk = 0;
    if (tick != 0) begin
      j    = $urandom_range(0, c_n - 1);
      dx   = w12(m_x[j] + $urandom_range(0, 150) - 50);
      dy   = w12(m_y[j] - 61 + $urandom_range(0, 10));
      fall = ($urandom_range(0, 3) != 0) ? 1 : 0;
      sreq = ($urandom_range(0, 99) < shift_prob) ? 1 : 0;
      r    = ($urandom_range(0, 7) == 0) ? 30'd0 : 30'($urandom);
      bus.doodle_x       = 12'(dx);
      bus.doodle_y       = 12'(dy);
      bus.doodle_falling = fall[0];
      bus.shift_req      = sreq[0];
      bus.rnd            = r;
      model_frame(sreq, r, dx, dy, fall);
    end
    bus.frame_tick = tick[0];
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.shift_req  = 1'b0;
    check_outputs();
    if (tick != 0) check_state();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst                = 1'b1;
    bus.frame_tick     = 1'b0;
    bus.rnd            = '0;
    bus.shift_req      = 1'b0;
    bus.doodle_x       = '0;
    bus.doodle_y       = '0;
    bus.doodle_falling = 1'b0;
    bus.beam_x         = '0;
    bus.beam_y         = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    e_hit = 0; e_idx = 0; e_kind = 0; e_dx = 0; e_dy = 0;
    e_land = 0; e_brk = 0;
    check_outputs();
    check_state();
    check("rst_y4", bus.plat_y[4], -132);
    check("rst_x4", bus.plat_x[4], 456);
    rst = 1'b0;

    // Mostly continuous scrolling, a quiet stretch so bursts end, then more.
    for (int f = 0; f < 700; f++) begin
      cycle(1, (f >= 300 && f < 360) ? 0 : ((f % 97 < 40) ? 3 : 25));
      for (int c = 0; c < 2 + (f % 3); c++) cycle(0, 0);
    end

    // A frame tick coinciding with reset must lose to reset.
    rst            = 1'b1;
    bus.frame_tick = 1'b1;
    bus.shift_req  = 1'b1;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.frame_tick = 1'b0;
    bus.shift_req  = 1'b0;
    model_reset();
    e_hit = 0; e_idx = 0; e_kind = 0; e_dx = 0; e_dy = 0;
    e_land = 0; e_brk = 0;
    check_outputs();
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
